// File: rtl/gpu_pkg.sv
// Shared GPU definitions: tile geometry, pixel-generator FSM states and
// attribute byte layout.
package gpu_pkg;

    // Tiles are 8x8 source pixels.
    localparam int unsigned TILE_SIZE_LOG2 = 3;

    // Attribute byte: foreground palette index in the high nibble,
    // background palette index in the low nibble.
    localparam int unsigned ATTR_FG_MSB = 7;
    localparam int unsigned ATTR_FG_LSB = 4;
    localparam int unsigned ATTR_BG_MSB = 3;
    localparam int unsigned ATTR_BG_LSB = 0;

    // Pixel fetch sequence, one state per clk.
    typedef enum logic [2:0] {
        IDLE,
        TILE,
        PAT,
        COL,
        OUT,
        BLANK
    } gpu_state_t;

endpackage

// File: rtl/tile_pixel_generator.sv
// Tile-mode pixel generator: maps the beam position through scaling and
// scroll into a wrapped tile map, then walks tile/attribute, pattern and
// palette RAMs to produce one colour per pixel strobe.
module tile_pixel_generator
    import gpu_pkg::*;
#(
    parameter int unsigned MAP_COLS_LOG2     = 6,
    parameter int unsigned MAP_ROWS_LOG2     = 5,
    parameter int unsigned SCALE_LOG2        = 1,
    parameter int unsigned PIXEL_W           = 8,
    parameter int unsigned PATTERN_MSB_FIRST = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pixel_clk,
    input  logic                                   active,
    input  logic [9:0]                             cycle,
    input  logic [8:0]                             scanline,
    input  logic [MAP_COLS_LOG2+2:0]               scroll_x,
    input  logic [MAP_ROWS_LOG2+2:0]               scroll_y,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] tile_memory_read_addr,
    output logic                                   tile_memory_read_enable,
    input  logic [7:0]                             tile_memory_read_data,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] attribute_memory_read_addr,
    output logic                                   attribute_memory_read_enable,
    input  logic [7:0]                             attribute_memory_read_data,
    output logic [10:0]                            pattern_memory_read_addr,
    output logic                                   pattern_memory_read_enable,
    input  logic [7:0]                             pattern_memory_read_data,
    output logic [3:0]                             color_memory_read_addr,
    output logic                                   color_memory_read_enable,
    input  logic [PIXEL_W-1:0]                     color_memory_read_data,
    output logic [PIXEL_W-1:0]                     pixel_data,
    output logic                                   pixel_valid,
    output logic                                   overrun
);

    localparam int unsigned SXW = MAP_COLS_LOG2 + TILE_SIZE_LOG2;
    localparam int unsigned SYW = MAP_ROWS_LOG2 + TILE_SIZE_LOG2;

    gpu_state_t state, state_n;

    logic [SXW-1:0] sx_next, sx_q;
    logic [SYW-1:0] sy_next, sy_q;
    logic [7:0]     attr_q;
    logic           pat_bit;
    logic [2:0]     bit_idx;

    // Truncation to the map width makes the scroll wrap around the map edges.
    assign sx_next = SXW'(cycle >> SCALE_LOG2) + scroll_x;
    assign sy_next = SYW'(scanline >> SCALE_LOG2) + scroll_y;

    // Pattern bit order: column n uses bit n, or bit 7-n when MSB-first.
    assign bit_idx = (PATTERN_MSB_FIRST != 0) ? ~sx_q[2:0] : sx_q[2:0];
    assign pat_bit = pattern_memory_read_data[bit_idx];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Coordinate latch, attribute capture, pixel output and overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q        <= '0;
            sy_q        <= '0;
            attr_q      <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (state == IDLE && pixel_clk && active) begin
                sx_q <= sx_next;
                sy_q <= sy_next;
            end
            if (state != IDLE && pixel_clk) begin
                overrun <= 1'b1;
            end
            if (state == PAT) begin
                attr_q <= attribute_memory_read_data;
            end
            if (state == OUT) begin
                pixel_data  <= color_memory_read_data;
                pixel_valid <= 1'b1;
            end
            if (state == BLANK) begin
                pixel_data  <= '0;
                pixel_valid <= 1'b1;
            end
        end
    end

    // Next state and RAM address/enable strobes; addresses read as zero
    // outside the state that uses them.
    always_comb begin
        state_n                      = state;
        tile_memory_read_addr        = '0;
        tile_memory_read_enable      = 1'b0;
        attribute_memory_read_addr   = '0;
        attribute_memory_read_enable = 1'b0;
        pattern_memory_read_addr     = '0;
        pattern_memory_read_enable   = 1'b0;
        color_memory_read_addr       = '0;
        color_memory_read_enable     = 1'b0;
        case (state)
            IDLE: begin
                if (pixel_clk) begin
                    state_n = active ? TILE : BLANK;
                end
            end
            TILE: begin
                tile_memory_read_addr        = {sy_q[SYW-1:TILE_SIZE_LOG2], sx_q[SXW-1:TILE_SIZE_LOG2]};
                tile_memory_read_enable      = 1'b1;
                attribute_memory_read_addr   = {sy_q[SYW-1:TILE_SIZE_LOG2], sx_q[SXW-1:TILE_SIZE_LOG2]};
                attribute_memory_read_enable = 1'b1;
                state_n                      = PAT;
            end
            PAT: begin
                pattern_memory_read_addr   = {tile_memory_read_data, sy_q[2:0]};
                pattern_memory_read_enable = 1'b1;
                state_n                    = COL;
            end
            COL: begin
                color_memory_read_addr   = pat_bit ? attr_q[ATTR_FG_MSB:ATTR_FG_LSB]
                                                   : attr_q[ATTR_BG_MSB:ATTR_BG_LSB];
                color_memory_read_enable = 1'b1;
                state_n                  = OUT;
            end
            OUT: begin
                state_n = IDLE;
            end
            BLANK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_pixel_generator.sv
// Directed bench for tile_pixel_generator: two instances (LSB-first and
// MSB-first pattern order) share the stimulus and the RAM contents.
module tb_tile_pixel_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_clk = 1'b0;
    logic        active = 1'b0;
    logic [9:0]  cycle = '0;
    logic [8:0]  scanline = '0;
    logic [8:0]  scroll_x = '0;
    logic [7:0]  scroll_y = '0;

    logic [7:0]  tile_mem  [2048];
    logic [7:0]  attr_mem  [2048];
    logic [7:0]  pat_mem   [2048];
    logic [7:0]  color_mem [16];

    // DUT A (LSB-first) signals
    logic [10:0] a_ta, a_aa, a_pa;
    logic [3:0]  a_ca;
    logic        a_te, a_ae, a_pe, a_ce;
    logic [7:0]  a_td, a_ad, a_pd, a_cd;
    logic [7:0]  a_px;
    logic        a_pv, a_ov;

    // DUT B (MSB-first) signals
    logic [10:0] b_ta, b_aa, b_pa;
    logic [3:0]  b_ca;
    logic        b_te, b_ae, b_pe, b_ce;
    logic [7:0]  b_td, b_ad, b_pd, b_cd;
    logic [7:0]  b_px;
    logic        b_pv, b_ov;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tile_pixel_generator #(
        .MAP_COLS_LOG2(6), .MAP_ROWS_LOG2(5), .SCALE_LOG2(1),
        .PIXEL_W(8), .PATTERN_MSB_FIRST(0)
    ) dut_a (
        .clk(clk), .rst(rst), .pixel_clk(pixel_clk), .active(active),
        .cycle(cycle), .scanline(scanline), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .tile_memory_read_addr(a_ta), .tile_memory_read_enable(a_te),
        .tile_memory_read_data(a_td),
        .attribute_memory_read_addr(a_aa), .attribute_memory_read_enable(a_ae),
        .attribute_memory_read_data(a_ad),
        .pattern_memory_read_addr(a_pa), .pattern_memory_read_enable(a_pe),
        .pattern_memory_read_data(a_pd),
        .color_memory_read_addr(a_ca), .color_memory_read_enable(a_ce),
        .color_memory_read_data(a_cd),
        .pixel_data(a_px), .pixel_valid(a_pv), .overrun(a_ov)
    );

    tile_pixel_generator #(
        .MAP_COLS_LOG2(6), .MAP_ROWS_LOG2(5), .SCALE_LOG2(1),
        .PIXEL_W(8), .PATTERN_MSB_FIRST(1)
    ) dut_b (
        .clk(clk), .rst(rst), .pixel_clk(pixel_clk), .active(active),
        .cycle(cycle), .scanline(scanline), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .tile_memory_read_addr(b_ta), .tile_memory_read_enable(b_te),
        .tile_memory_read_data(b_td),
        .attribute_memory_read_addr(b_aa), .attribute_memory_read_enable(b_ae),
        .attribute_memory_read_data(b_ad),
        .pattern_memory_read_addr(b_pa), .pattern_memory_read_enable(b_pe),
        .pattern_memory_read_data(b_pd),
        .color_memory_read_addr(b_ca), .color_memory_read_enable(b_ce),
        .color_memory_read_data(b_cd),
        .pixel_data(b_px), .pixel_valid(b_pv), .overrun(b_ov)
    );

    // Synchronous RAM models, 1-clk read latency
    always @(posedge clk) begin
        if (a_te) a_td <= tile_mem[a_ta];
        if (a_ae) a_ad <= attr_mem[a_aa];
        if (a_pe) a_pd <= pat_mem[a_pa];
        if (a_ce) a_cd <= color_mem[a_ca];
        if (b_te) b_td <= tile_mem[b_ta];
        if (b_ae) b_ad <= attr_mem[b_aa];
        if (b_pe) b_pd <= pat_mem[b_pa];
        if (b_ce) b_cd <= color_mem[b_ca];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe during one clk; returns at the negedge of the following clk (N+1)
    task automatic strobe(input logic [9:0] c, input logic [8:0] s, input logic act,
                          input logic [8:0] scx, input logic [7:0] scy);
        @(negedge clk);
        cycle     = c;
        scanline  = s;
        scroll_x  = scx;
        scroll_y  = scy;
        active    = act;
        pixel_clk = 1'b1;
        @(negedge clk);
        pixel_clk = 1'b0;
    endtask

    task automatic run_pixel(input string tag, input logic [9:0] c, input logic [8:0] s,
                             input logic [8:0] scx, input logic [7:0] scy,
                             input logic [10:0] exp_ta, input logic [10:0] exp_pa,
                             input logic [3:0] exp_ca, input logic [7:0] exp_px,
                             input logic [3:0] exp_ca_b, input logic [7:0] exp_px_b);
        strobe(c, s, 1'b1, scx, scy);
        check({tag, ".tile_addr"}, a_ta, exp_ta);
        check({tag, ".attr_addr"}, a_aa, exp_ta);
        check({tag, ".tile_attr_en"}, {a_te, a_ae, a_pe, a_ce}, 4'b1100);
        @(negedge clk);
        check({tag, ".pat_addr"}, a_pa, exp_pa);
        check({tag, ".pat_en"}, {a_te, a_ae, a_pe, a_ce}, 4'b0010);
        @(negedge clk);
        check({tag, ".col_addr"}, a_ca, exp_ca);
        check({tag, ".col_en"}, {a_te, a_ae, a_pe, a_ce}, 4'b0001);
        check({tag, ".col_addr_b"}, b_ca, exp_ca_b);
        @(negedge clk);
        check({tag, ".valid_n4"}, a_pv, 1'b0);
        @(negedge clk);
        check({tag, ".valid_n5"}, a_pv, 1'b1);
        check({tag, ".pixel"}, a_px, exp_px);
        check({tag, ".pixel_b"}, b_px, exp_px_b);
        @(negedge clk);
        check({tag, ".valid_n6"}, a_pv, 1'b0);
        check({tag, ".pixel_hold"}, a_px, exp_px);
    endtask

    function automatic logic [50:0] all_outs_a();
        return {a_ta, a_te, a_aa, a_ae, a_pa, a_pe, a_ca, a_ce, a_px, a_pv, a_ov};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        for (int i = 0; i < 2048; i++) begin
            tile_mem[i] = '0;
            attr_mem[i] = '0;
            pat_mem[i]  = '0;
        end
        for (int i = 0; i < 16; i++) color_mem[i] = '0;
        color_mem[0]  = 8'h11;
        // test 2 contents: x=9 (col 1, fcol 1), y=17 (row 2, frow 1)
        tile_mem[11'h081] = 8'h41;
        attr_mem[11'h081] = 8'hF0;
        pat_mem[11'h209]  = 8'h02;
        color_mem[15]     = 8'hAA;
        // test 3 contents: sx=510 (col 63, fcol 6), sy=1 (row 0, frow 1)
        tile_mem[63]  = 8'h05;
        attr_mem[63]  = 8'h3C;
        pat_mem[41]   = 8'h40;
        color_mem[3]  = 8'h77;
        color_mem[12] = 8'hCC;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs_a(), '0);
        rst = 1'b0;

        // MSB-first instance picks bit 6 of 0x02 (clear) -> bg 0 -> 0x11
        run_pixel("basic", 10'd18, 9'd34, 9'd0, 8'd0,
                  11'h081, 11'h209, 4'd15, 8'hAA, 4'd0, 8'h11);

        // reset in the middle of a fetch
        strobe(10'd18, 9'd34, 1'b1, 9'd0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", all_outs_a(), '0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_pv) pulses++;
        end
        check("aborted_no_valid", pulses, 0);

        run_pixel("origin", 10'd0, 9'd0, 9'd0, 8'd0,
                  11'd0, 11'd0, 4'd0, 8'h11, 4'd0, 8'h11);

        // sx=(511+511)%512=510, sy=(2+255)%256=1; MSB-first: bit 1 of 0x40 clear -> bg C
        run_pixel("wrap", 10'd1022, 9'd4, 9'd511, 8'd255,
                  11'd63, 11'h029, 4'd3, 8'h77, 4'hC, 8'hCC);

        // blanked pixel
        strobe(10'd18, 9'd34, 1'b0, 9'd0, 8'd0);
        check("blank_no_en_n1", {a_te, a_ae, a_pe, a_ce}, 4'b0000);
        check("blank_valid_n1", a_pv, 1'b0);
        @(negedge clk);
        check("blank_valid_n2", a_pv, 1'b1);
        check("blank_pixel", a_px, 8'h00);
        check("blank_no_en_n2", {a_te, a_ae, a_pe, a_ce}, 4'b0000);
        @(negedge clk);
        check("blank_valid_n3", a_pv, 1'b0);
        check("blank_hold", a_px, 8'h00);

        // overrun: second strobe 3 clk after the first
        strobe(10'd0, 9'd0, 1'b1, 9'd0, 8'd0);
        @(negedge clk);
        check("overrun_before", a_ov, 1'b0);
        @(negedge clk);
        pixel_clk = 1'b1;
        @(negedge clk);
        pixel_clk = 1'b0;
        check("overrun_set", a_ov, 1'b1);
        @(negedge clk);
        check("overrun_first_completes", a_pv, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_pv) pulses++;
        end
        check("overrun_second_ignored", pulses, 0);
        check("overrun_sticky", a_ov, 1'b1);
        rst = 1'b1;
        #1;
        check("overrun_cleared", a_ov, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // pattern bit order: pattern 0x80 at fcol 0
        attr_mem[0]   = 8'h5A;
        pat_mem[0]    = 8'h80;
        color_mem[5]  = 8'h55;
        color_mem[10] = 8'hA5;
        run_pixel("order", 10'd0, 9'd0, 9'd0, 8'd0,
                  11'd0, 11'd0, 4'hA, 8'hA5, 4'h5, 8'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
